// File: rtl/sargantana_icache_pkg.sv
// Shared types and default sizing for the Sargantana instruction-cache flush logic.
//   DEFAULT_DEPTH    : default number of cache sets
//   DEFAULT_NUM_WAYS : default number of ways
//   flush_state_e    : flush controller FSM state
package sargantana_icache_pkg;

   localparam int unsigned DEFAULT_DEPTH    = 64;
   localparam int unsigned DEFAULT_NUM_WAYS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } flush_state_e;

endpackage

// File: rtl/sargantana_icache_flush_ctrl.sv
// Instruction-cache flush controller: walks a full or ranged (wrapping) set
// interval, emitting one invalidate command per set for the latched way mask.
// Requests arriving while busy are coalesced into a single pending flush.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_req_i            single-cycle flush request
//   flush_all_i            sweep every set (range ignored)
//   start_idx_i/end_idx_i  inclusive set range, may wrap
//   way_mask_i             ways to invalidate
//   stall_i                array busy, current command not accepted
//   inv_valid_o/idx/way    invalidate command
//   busy_o                 sweep in progress or request pending
//   done_o                 one-cycle completion pulse
module sargantana_icache_flush_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter int unsigned NUM_WAYS = DEFAULT_NUM_WAYS,
   parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_req_i,
   input  logic                flush_all_i,
   input  logic [IDX_W-1:0]    start_idx_i,
   input  logic [IDX_W-1:0]    end_idx_i,
   input  logic [NUM_WAYS-1:0] way_mask_i,
   input  logic                stall_i,
   output logic                inv_valid_o,
   output logic [IDX_W-1:0]    inv_idx_o,
   output logic [NUM_WAYS-1:0] inv_way_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int unsigned CNT_W = IDX_W + 1;

   flush_state_e        state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_WAYS-1:0] way_q, way_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                pend_q, pend_d;
   logic                pend_all_q, pend_all_d;
   logic [IDX_W-1:0]    pend_start_q, pend_start_d;
   logic [IDX_W-1:0]    pend_end_q, pend_end_d;
   logic [NUM_WAYS-1:0] pend_mask_q, pend_mask_d;

   logic                load_c;
   logic                accept_c;
   logic                ld_all_c;
   logic [IDX_W-1:0]    ld_start_c;
   logic [IDX_W-1:0]    ld_end_c;
   logic [NUM_WAYS-1:0] ld_mask_c;

   // Number of sets in a sweep; a wrapping range is handled by modular subtraction.
   function automatic logic [CNT_W-1:0] sweep_len(input logic             all,
                                                  input logic [IDX_W-1:0] s,
                                                  input logic [IDX_W-1:0] e);
      logic [IDX_W-1:0] span;
      span = e - s;
      if (all) begin
         return CNT_W'(DEPTH);
      end
      return {1'b0, span} + CNT_W'(1);
   endfunction

   // Parameters for a new sweep: a fresh request wins over older pending ones.
   always_comb begin
      ld_all_c   = pend_all_q;
      ld_start_c = pend_start_q;
      ld_end_c   = pend_end_q;
      ld_mask_c  = pend_mask_q;
      if (flush_req_i) begin
         ld_all_c   = flush_all_i;
         ld_start_c = start_idx_i;
         ld_end_c   = end_idx_i;
         ld_mask_c  = way_mask_i;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      way_d        = way_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      pend_all_d   = pend_all_q;
      pend_start_d = pend_start_q;
      pend_end_d   = pend_end_q;
      pend_mask_d  = pend_mask_q;
      load_c       = 1'b0;
      accept_c     = 1'b0;

      // Requests while busy are parked; the latest one overwrites earlier ones.
      if (flush_req_i && (state_q != ST_IDLE)) begin
         pend_d       = 1'b1;
         pend_all_d   = flush_all_i;
         pend_start_d = start_idx_i;
         pend_end_d   = end_idx_i;
         pend_mask_d  = way_mask_i;
      end

      unique case (state_q)
         ST_IDLE: begin
            load_c = flush_req_i;
         end
         ST_SWEEP: begin
            accept_c = ~stall_i;
            if (accept_c) begin
               idx_d = idx_q + IDX_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Chain straight into the parked (or same-cycle) request.
            state_d = ST_IDLE;
            load_c  = flush_req_i | pend_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_c) begin
         state_d = ST_SWEEP;
         idx_d   = ld_all_c ? '0 : ld_start_c;
         way_d   = ld_mask_c;
         cnt_d   = sweep_len(ld_all_c, ld_start_c, ld_end_c);
         pend_d  = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         way_q        <= '0;
         cnt_q        <= '0;
         pend_q       <= 1'b0;
         pend_all_q   <= 1'b0;
         pend_start_q <= '0;
         pend_end_q   <= '0;
         pend_mask_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         way_q        <= way_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         pend_all_q   <= pend_all_d;
         pend_start_q <= pend_start_d;
         pend_end_q   <= pend_end_d;
         pend_mask_q  <= pend_mask_d;
      end
   end

   // Outputs decoded from registered state only; command fields forced to 0 outside a sweep.
   assign inv_valid_o = (state_q == ST_SWEEP);
   assign inv_idx_o   = (state_q == ST_SWEEP) ? idx_q : '0;
   assign inv_way_o   = (state_q == ST_SWEEP) ? way_q : '0;
   assign done_o      = (state_q == ST_DONE);
   assign busy_o      = (state_q != ST_IDLE) | pend_q;

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Self-checking bench for sargantana_icache_flush_ctrl (DEPTH=64, NUM_WAYS=4).
// Expected command streams are enumerated set-by-set from the flush rules.
module tb_sargantana_icache_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush_req;
   logic       flush_all;
   logic [5:0] start_idx;
   logic [5:0] end_idx;
   logic [3:0] way_mask;
   logic       stall;
   logic       inv_valid;
   logic [5:0] inv_idx;
   logic [3:0] inv_way;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   int exp_a[$];
   int exp_b[$];

   sargantana_icache_flush_ctrl #(.DEPTH(64), .NUM_WAYS(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_req_i(flush_req),
      .flush_all_i(flush_all),
      .start_idx_i(start_idx),
      .end_idx_i  (end_idx),
      .way_mask_i (way_mask),
      .stall_i    (stall),
      .inv_valid_o(inv_valid),
      .inv_idx_o  (inv_idx),
      .inv_way_o  (inv_way),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string name);
      check({name, ":valid"}, 32'(inv_valid), 0);
      check({name, ":idx"},   32'(inv_idx),   0);
      check({name, ":way"},   32'(inv_way),   0);
      check({name, ":done"},  32'(done),      0);
      check({name, ":busy"},  32'(busy),      0);
   endtask

   // Enumerate the sets a flush must visit, in order.
   task automatic push_range(input bit to_b, input int s, input int e, input bit all);
      int i;
      if (all) begin
         for (int k = 0; k < 64; k++) begin
            if (to_b) exp_b.push_back(k); else exp_a.push_back(k);
         end
      end else begin
         i = s;
         if (to_b) exp_b.push_back(i); else exp_a.push_back(i);
         while (i != e) begin
            i = (i + 1) % 64;
            if (to_b) exp_b.push_back(i); else exp_a.push_back(i);
         end
      end
   endtask

   task automatic issue(input int s, input int e, input bit all, input logic [3:0] m);
      flush_req = 1'b1;
      flush_all = all;
      start_idx = 6'(s);
      end_idx   = 6'(e);
      way_mask  = m;
   endtask

   task automatic scramble();
      flush_req = 1'b0;
      flush_all = 1'($urandom);
      start_idx = 6'($urandom);
      end_idx   = 6'($urandom);
      way_mask  = 4'($urandom);
   endtask

   // One flush from idle, with optional random stalls, checked against exp_a.
   task automatic run_flush(input string name, input int s, input int e, input bit all,
                            input logic [3:0] m, input int stall_pct, input int exp_len,
                            input bit timing);
      int cyc;
      int acc;
      int want;
      bit seen;
      exp_a.delete();
      push_range(1'b0, s, e, all);
      issue(s, e, all, m);
      stall = 1'b0;
      step();
      scramble();
      check({name, ":busy_start"}, 32'(busy), 1);
      cyc  = 1;
      acc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 2000) begin
         stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
         if (done) begin
            seen = 1'b1;
            check({name, ":done_valid"}, 32'(inv_valid), 0);
            check({name, ":accepts"}, 32'(acc), 32'(exp_len));
            if (timing) check({name, ":done_cycle"}, 32'(cyc), 32'(exp_len + 1));
         end else if (inv_valid !== 1'b1) begin
            check($sformatf("%s:gap@%0d", name, cyc), 32'(inv_valid), 1);
         end else if (!stall) begin
            want = (exp_a.size() > 0) ? exp_a.pop_front() : -1;
            check($sformatf("%s:idx#%0d", name, acc), 32'(inv_idx), 32'(want));
            check($sformatf("%s:way#%0d", name, acc), 32'(inv_way), 32'(m));
            acc++;
         end
         step();
         cyc++;
      end
      stall = 1'b0;
      check({name, ":done_seen"}, 32'(seen), 1);
      check({name, ":busy_after"}, 32'(busy), 0);
      check({name, ":valid_after"}, 32'(inv_valid), 0);
   endtask

   // A second request arrives mid-sweep (optionally preceded by a decoy that must be overwritten).
   task automatic run_overlap(input string name, input int s1, input int e1, input bit all1,
                              input int trig, input bit decoy,
                              input int s2, input int e2, input logic [3:0] m2);
      int cyc;
      int phase;
      int want;
      bit fired;
      logic [3:0] wm;
      exp_a.delete();
      exp_b.delete();
      push_range(1'b0, s1, e1, all1);
      push_range(1'b1, s2, e2, 1'b0);
      stall = 1'b0;
      issue(s1, e1, all1, 4'hF);
      step();
      scramble();
      cyc   = 0;
      phase = 0;
      fired = 1'b0;
      while (phase < 2 && cyc < 2000) begin
         flush_req = 1'b0;
         if (decoy && cyc == 0) issue((s2 + 7) % 64, (e2 + 9) % 64, 1'b0, ~m2);
         if (done) begin
            if (phase == 0) begin
               check({name, ":first_left"}, 32'(exp_a.size()), 0);
               check({name, ":pend_busy"}, 32'(busy), 1);
            end else begin
               check({name, ":second_left"}, 32'(exp_b.size()), 0);
            end
            phase++;
         end else if (inv_valid !== 1'b1) begin
            check($sformatf("%s:gap@%0d", name, cyc), 32'(inv_valid), 1);
         end else begin
            if (phase == 0) begin
               want = (exp_a.size() > 0) ? exp_a.pop_front() : -1;
               wm   = 4'hF;
            end else begin
               want = (exp_b.size() > 0) ? exp_b.pop_front() : -1;
               wm   = m2;
            end
            check($sformatf("%s:idx p%0d c%0d", name, phase, cyc), 32'(inv_idx), 32'(want));
            check($sformatf("%s:way p%0d c%0d", name, phase, cyc), 32'(inv_way), 32'(wm));
            if (phase == 0 && !fired && inv_idx == 6'(trig)) begin
               issue(s2, e2, 1'b0, m2);
               fired = 1'b1;
            end
         end
         step();
         cyc++;
      end
      flush_req = 1'b0;
      check({name, ":both_done"}, 32'(phase), 2);
      check({name, ":busy_after"}, 32'(busy), 0);
   endtask

   typedef struct {
      string      name;
      int         s;
      int         e;
      bit         all;
      logic [3:0] m;
      int         stall_pct;
      int         len;
      bit         timing;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int found;
      int s;
      int e;
      bit all;

      rst = 1'b1; flush_req = 1'b0; flush_all = 1'b0;
      start_idx = '0; end_idx = '0; way_mask = '0; stall = 1'b0;
      step();
      step();
      check_idle("reset");
      rst = 1'b0;
      step();
      check_idle("post_reset");

      tbl[0] = '{"full",      17, 3,  1'b1, 4'hF,    0,  64, 1'b1};
      tbl[1] = '{"wrap60_3",  60, 3,  1'b0, 4'b0101, 0,  8,  1'b1};
      tbl[2] = '{"r10_12",    10, 12, 1'b0, 4'hF,    0,  3,  1'b1};
      tbl[3] = '{"single5",   5,  5,  1'b0, 4'b0010, 0,  1,  1'b1};
      tbl[4] = '{"r0_63",     0,  63, 1'b0, 4'hF,    0,  64, 1'b1};
      tbl[5] = '{"wrap63_0",  63, 0,  1'b0, 4'hA,    0,  2,  1'b1};
      tbl[6] = '{"mask0_7_6", 7,  6,  1'b0, 4'h0,    0,  64, 1'b1};
      tbl[7] = '{"stall20",   20, 25, 1'b0, 4'hF,    40, 6,  1'b0};
      tbl[8] = '{"stall50_10",50, 10, 1'b0, 4'b0011, 30, 25, 1'b0};
      foreach (tbl[i]) begin
         run_flush(tbl[i].name, tbl[i].s, tbl[i].e, tbl[i].all, tbl[i].m,
                   tbl[i].stall_pct, tbl[i].len, tbl[i].timing);
         step();
      end

      // Stall held on the middle set of a three-set flush.
      issue(10, 12, 1'b0, 4'hF);
      step();
      scramble();
      check("stall:idx10", 32'(inv_idx), 10);
      step();
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall:hold%0d", k), {26'd0, inv_valid, inv_idx}, {26'd0, 1'b1, 6'd11});
         step();
      end
      stall = 1'b0;
      check("stall:idx11", 32'(inv_idx), 11);
      step();
      check("stall:idx12", 32'(inv_idx), 12);
      step();
      check("stall:done", 32'(done), 1);
      step();
      check_idle("stall:after");

      // Second request mid full sweep, and a request on the very last accept (with coalescing).
      run_overlap("ovl_full", 0, 63, 1'b1, 20, 1'b0, 5, 5, 4'b0011);
      step();
      run_overlap("ovl_last", 1, 2, 1'b0, 2, 1'b1, 40, 41, 4'b1000);
      step();

      // Reset in the middle of a full sweep.
      issue(0, 0, 1'b1, 4'hF);
      step();
      scramble();
      found = 0;
      for (int k = 0; k < 100 && found == 0; k++) begin
         if (inv_valid && inv_idx == 6'd30) found = 1;
         else step();
      end
      check("rst:reached30", 32'(found), 1);
      rst = 1'b1;
      issue(9, 9, 1'b0, 4'h1);
      step();
      rst = 1'b0;
      flush_req = 1'b0;
      check_idle("rst:after");
      for (int k = 0; k < 3; k++) begin
         step();
         check_idle($sformatf("rst:quiet%0d", k));
      end
      run_flush("rst:restart", 0, 0, 1'b1, 4'hF, 0, 64, 1'b1);
      step();

      // Randomised flushes against the enumerated-set model.
      for (int r = 0; r < 25; r++) begin
         s   = int'($urandom_range(0, 63));
         e   = int'($urandom_range(0, 63));
         all = ($urandom_range(0, 7) == 0);
         run_flush($sformatf("rnd%0d", r), s, e, all, 4'($urandom),
                   int'($urandom_range(0, 50)), all ? 64 : (((e - s + 64) % 64) + 1), 1'b0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
